// File: rtl/rtc_bus_pkg.sv
// Shared encodings and default timing for the RTC multiplexed bus cycle generator.
package rtc_bus_pkg;

  localparam logic [1:0] TIPO_DIR_WR  = 2'b00;
  localparam logic [1:0] TIPO_DAT_WR  = 2'b01;
  localparam logic [1:0] TIPO_DAT_RD  = 2'b10;
  localparam logic [1:0] TIPO_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRecover
  } rtc_state_e;

  localparam int unsigned T_SETUP_DEF   = 2;
  localparam int unsigned T_PULSE_DEF   = 10;
  localparam int unsigned T_HOLD_DEF    = 2;
  localparam int unsigned T_RECOVER_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 8;

  // A zero timing value behaves as a single cycle.
  function automatic int unsigned t_min1(input int unsigned t);
    return (t == 0) ? 1 : t;
  endfunction

endpackage

// File: rtl/rtc_bus_timer.sv
// Loadable down-counter that parks at zero; zero flag tells the FSM a phase has expired.
module rtc_bus_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Turns one req into a full multiplexed address/data cycle on the RTC pins.
// All pin outputs are registered so the pads never see combinational glitches.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP   = T_SETUP_DEF,
  parameter int unsigned T_PULSE   = T_PULSE_DEF,
  parameter int unsigned T_HOLD    = T_HOLD_DEF,
  parameter int unsigned T_RECOVER = T_RECOVER_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] req_tipo,
  input  logic [7:0] bus_in,
  input  logic [7:0] rtc_din,
  output logic [7:0] rtc_dout,
  output logic       rtc_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] SetupLd   = CNT_W'(t_min1(T_SETUP) - 1);
  localparam logic [CNT_W-1:0] PulseLd   = CNT_W'(t_min1(T_PULSE) - 1);
  // HOLD begins on the strobe-rise edge, so CS# stays low for that cycle plus T_HOLD more.
  localparam logic [CNT_W-1:0] HoldLd    = CNT_W'(t_min1(T_HOLD));
  localparam logic [CNT_W-1:0] RecoverLd = CNT_W'(t_min1(T_RECOVER) - 1);

  rtc_state_e       state_d, state_q;
  logic [1:0]       tipo_d, tipo_q;
  logic [7:0]       dout_d, dout_q;
  logic [7:0]       data_rd_d, data_rd_q;
  logic             oe_d, oe_q;
  logic             cs_n_d, cs_n_q;
  logic             rd_n_d, rd_n_q;
  logic             wr_n_d, wr_n_q;
  logic             ad_d, ad_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  rtc_bus_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state_q != StIdle),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    tipo_d    = tipo_q;
    dout_d    = dout_q;
    data_rd_d = data_rd_q;
    oe_d      = oe_q;
    cs_n_d    = cs_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = wr_n_q;
    ad_d      = ad_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    unique case (state_q)
      StIdle: begin
        if (req && (req_tipo != TIPO_ILLEGAL)) begin
          state_d  = StSetup;
          tipo_d   = req_tipo;
          dout_d   = bus_in;
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          ad_d     = (req_tipo != TIPO_DIR_WR);
          oe_d     = (req_tipo != TIPO_DAT_RD);
          tmr_load = 1'b1;
          tmr_val  = SetupLd;
        end
      end
      StSetup: begin
        if (tmr_zero) begin
          state_d  = StStrobe;
          if (tipo_q == TIPO_DAT_RD) begin
            rd_n_d = 1'b0;
          end else begin
            wr_n_d = 1'b0;
          end
          tmr_load = 1'b1;
          tmr_val  = PulseLd;
        end
      end
      StStrobe: begin
        if (tmr_zero) begin
          state_d = StHold;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          if (tipo_q == TIPO_DAT_RD) begin
            data_rd_d = rtc_din;
          end
          tmr_load = 1'b1;
          tmr_val  = HoldLd;
        end
      end
      StHold: begin
        if (tmr_zero) begin
          state_d  = StRecover;
          cs_n_d   = 1'b1;
          oe_d     = 1'b0;
          ad_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = RecoverLd;
        end
      end
      StRecover: begin
        if (tmr_zero) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      tipo_q    <= TIPO_DIR_WR;
      dout_q    <= '0;
      data_rd_q <= '0;
      oe_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tipo_q    <= tipo_d;
      dout_q    <= dout_d;
      data_rd_q <= data_rd_d;
      oe_q      <= oe_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_q      <= ad_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rtc_dout = dout_q;
  assign rtc_oe   = oe_q;
  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign ad       = ad_q;
  assign data_rd  = data_rd_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Directed scoreboard bench for rtc_bus_cycle: default timing plus a fast-timing instance.
module tb_rtc_bus_cycle;
  import rtc_bus_pkg::*;

  localparam int CsLow   = 15;
  localparam int SetupC  = 2;
  localparam int PulseC  = 10;
  localparam int RecC    = 4;
  localparam int Latency = 19;

  typedef struct {
    logic [7:0] dout;
    logic [7:0] data_rd;
    logic       ad;
    logic       oe;
    logic       rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, req, f_req;
  logic [1:0] req_tipo;
  logic [7:0] bus_in, rtc_din;
  logic [7:0] rtc_dout, data_rd, f_rtc_dout, f_data_rd;
  logic       rtc_oe, cs_n, rd_n, wr_n, ad, busy, done;
  logic       f_rtc_oe, f_cs_n, f_rd_n, f_wr_n, f_ad, f_busy, f_done;

  int         total = 0;
  int         bad = 0;
  exp_t       sb[$];
  logic [7:0] model_rd = 8'h00;
  logic       inv_on = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_cycle dut (
    .clk(clk), .reset(reset), .req(req), .req_tipo(req_tipo), .bus_in(bus_in),
    .rtc_din(rtc_din), .rtc_dout(rtc_dout), .rtc_oe(rtc_oe), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .ad(ad), .data_rd(data_rd), .busy(busy), .done(done)
  );

  rtc_bus_cycle #(
    .T_SETUP (0),
    .T_PULSE (1)
  ) dut_f (
    .clk(clk), .reset(reset), .req(f_req), .req_tipo(req_tipo), .bus_in(bus_in),
    .rtc_din(rtc_din), .rtc_dout(f_rtc_dout), .rtc_oe(f_rtc_oe), .cs_n(f_cs_n),
    .rd_n(f_rd_n), .wr_n(f_wr_n), .ad(f_ad), .data_rd(f_data_rd), .busy(f_busy),
    .done(f_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic inv_ok(input logic c, input logic r, input logic w, input logic o);
    return !(!r && !w) && !((!r || !w) && c) && !(o && !r);
  endfunction

  // Every sample point also checks the pin protocol on both instances.
  task automatic tick();
    @(negedge clk);
    if (inv_on && reset === 1'b1) begin
      check("inv_main", 32'(inv_ok(cs_n, rd_n, wr_n, rtc_oe)), 32'd1);
      check("inv_fast", 32'(inv_ok(f_cs_n, f_rd_n, f_wr_n, f_rtc_oe)), 32'd1);
    end
  endtask

  task automatic drive_req(input logic [1:0] t, input logic [7:0] b, input logic [7:0] din);
    exp_t e;
    req      = 1'b1;
    req_tipo = t;
    bus_in   = b;
    rtc_din  = din;
    e.dout   = b;
    e.ad     = (t != TIPO_DIR_WR);
    e.oe     = (t != TIPO_DAT_RD);
    e.rd     = (t == TIPO_DAT_RD);
    if (e.rd) model_rd = din;
    e.data_rd = model_rd;
    sb.push_back(e);
    tick();
    req      = 1'b0;
    req_tipo = ~t;
    bus_in   = ~b;
  endtask

  // Called on the first sample after the accepting edge; returns on the done sample.
  task automatic measure(input int poke);
    exp_t e;
    int   edges, cs_low, setup, strobe, busy_cnt, rec;
    logic seen, got, ad_bad, oe_bad, dout_bad, wrong;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    {cs_low, setup, strobe, busy_cnt, rec} = '0;
    {seen, got, ad_bad, oe_bad, dout_bad, wrong} = '0;
    for (edges = 0; edges <= 60; edges++) begin
      if (edges == 0) begin
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_cs", 32'(cs_n), 32'd0);
      end
      if (edges == poke) begin
        req = 1'b1; req_tipo = TIPO_DAT_WR; bus_in = 8'h77;
      end
      if (edges == poke + 2) req = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (cs_n === 1'b0) begin
        cs_low++;
        if (ad !== e.ad) ad_bad = 1'b1;
        if (rtc_oe !== e.oe) oe_bad = 1'b1;
        if (rtc_dout !== e.dout) dout_bad = 1'b1;
        if (!seen && rd_n === 1'b1 && wr_n === 1'b1) setup++;
      end
      if (rd_n === 1'b0 || wr_n === 1'b0) begin
        seen = 1'b1;
        strobe++;
        if (e.rd ? (wr_n === 1'b0) : (rd_n === 1'b0)) wrong = 1'b1;
      end
      if (cs_n === 1'b1 && busy === 1'b1) rec++;
      tick();
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", edges, Latency);
    check("cs_low", cs_low, CsLow);
    check("setup", setup, SetupC);
    check("strobe", strobe, PulseC);
    check("busy_cycles", busy_cnt, Latency);
    check("recover_cs_high", rec, RecC);
    check("ad_stable", 32'(ad_bad), 32'd0);
    check("oe_stable", 32'(oe_bad), 32'd0);
    check("dout_stable", 32'(dout_bad), 32'd0);
    check("strobe_kind", 32'(wrong), 32'd0);
    check("data_rd", 32'(data_rd), 32'(e.data_rd));
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_cs", 32'(cs_n), 32'd1);
      check("idle_done", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int   wait_cnt;
    int   f_edges, f_setup, f_strobe;
    logic f_seen, f_got;
    reset = 1'b0; req = 1'b0; f_req = 1'b0;
    req_tipo = TIPO_DIR_WR; bus_in = 8'h00; rtc_din = 8'h00;
    repeat (3) tick();
    check("rst_cs", 32'(cs_n), 32'd1);
    check("rst_rd", 32'(rd_n), 32'd1);
    check("rst_wr", 32'(wr_n), 32'd1);
    check("rst_ad", 32'(ad), 32'd0);
    check("rst_oe", 32'(rtc_oe), 32'd0);
    check("rst_dout", 32'(rtc_dout), 32'h00);
    check("rst_data_rd", 32'(data_rd), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    inv_on = 1'b1;
    tick();

    // Address write, then single-cycle done.
    drive_req(TIPO_DIR_WR, 8'h21, 8'h00);
    measure(-10);
    idle_check(2);

    // Data read, then a write must leave data_rd alone.
    drive_req(TIPO_DAT_RD, 8'h40, 8'h59);
    measure(-10);
    rtc_din = 8'hC3;
    idle_check(1);
    drive_req(TIPO_DAT_WR, 8'h00, 8'hC3);
    measure(-10);
    idle_check(1);

    // Back-to-back: second req issued in the done cycle.
    drive_req(TIPO_DIR_WR, 8'h05, 8'hC3);
    measure(-10);
    drive_req(TIPO_DAT_RD, 8'h05, 8'h2A);
    measure(-10);
    idle_check(1);

    // Illegal tipo is ignored.
    req = 1'b1; req_tipo = TIPO_ILLEGAL; bus_in = 8'hEE;
    idle_check(4);
    req = 1'b0;
    idle_check(1);

    // req while busy is neither accepted nor queued.
    drive_req(TIPO_DAT_WR, 8'h33, 8'h2A);
    measure(5);
    idle_check(25);

    // Reset in the middle of a write strobe.
    drive_req(TIPO_DAT_WR, 8'hA5, 8'h2A);
    wait_cnt = 0;
    while (wr_n !== 1'b0 && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    check("rst_mid_strobe_seen", 32'(wr_n), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("abort_wr", 32'(wr_n), 32'd1);
    check("abort_cs", 32'(cs_n), 32'd1);
    check("abort_oe", 32'(rtc_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data_rd", 32'(data_rd), 32'h00);
    void'(sb.pop_back());
    model_rd = 8'h00;
    reset = 1'b1;
    tick();
    drive_req(TIPO_DAT_RD, 8'h11, 8'h3C);
    measure(-10);
    idle_check(1);

    // Fast instance: T_SETUP=0 acts as 1, T_PULSE=1.
    f_req = 1'b1; req_tipo = TIPO_DAT_WR; bus_in = 8'h9A;
    tick();
    f_req = 1'b0;
    {f_setup, f_strobe, f_seen, f_got} = '0;
    for (f_edges = 0; f_edges <= 40; f_edges++) begin
      if (f_done === 1'b1) begin
        f_got = 1'b1;
        break;
      end
      if (f_cs_n === 1'b0 && !f_seen && f_wr_n === 1'b1) f_setup++;
      if (f_wr_n === 1'b0) begin
        f_seen = 1'b1;
        f_strobe++;
      end
      tick();
    end
    check("fast_done", 32'(f_got), 32'd1);
    check("fast_setup", f_setup, 1);
    check("fast_strobe", f_strobe, 1);
    check("fast_dout", 32'(f_rtc_dout), 32'h9A);
    tick();
    check("fast_done_pulse", 32'(f_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
